// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared definitions for the time-shared signed multiplier.
//   state_t : controller states (IDLE, MUL, RESP)
//   OPW     : operand width (signed 8-bit)
//   RESW    : product width (signed 16-bit, full precision)
package mult_share_pkg;
  localparam int OPW  = 8;
  localparam int RESW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: purely combinational round-robin arbiter.
// Searches req starting at index ptr, wrapping modulo N, and grants the
// first active request.
// Ports:
//   req     in  [N-1:0]  request vector
//   ptr     in  [PW-1:0] highest-priority index (must be < N)
//   gnt     out [N-1:0]  one-hot grant, all zero when req == 0
//   gnt_idx out [PW-1:0] encoded index of the grant (0 when no grant)
module rr_arbiter_onehot #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic          found;
  logic [PW:0]   pos;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // One spare bit so ptr+k cannot overflow before the modulo-N wrap.
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_rr.sv
// mult_share_rr: one signed 8x8 multiplier shared by NUM_REQ requesters
// through a round-robin arbiter. Operands and product are registered, so a
// request accepted at cycle T shows resp_valid at T+2; at most one operation
// is in flight (IDLE -> MUL -> RESP).
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot)
//   req_a, req_x      packed signed operands, requester i at [8i+7:8i]
//   resp_valid/ready  shared response handshake
//   resp_result       signed 16-bit product
//   resp_id           index of the requester owning resp_result
// Optional build macro MULT_SHARE_PERF_EN adds:
//   perf_ops   32-bit count of response handshakes
//   perf_busy  32-bit count of cycles spent outside IDLE
module mult_share_rr
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_x,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  output logic [RESW-1:0]        resp_result,
  output logic [ID_W-1:0]        resp_id,
  input  logic                   resp_ready
`ifdef MULT_SHARE_PERF_EN
  ,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_busy
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                  state;
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           gnt_idx;
  logic [NUM_REQ-1:0]      gnt;
  logic                    xfer;
  logic signed [OPW-1:0]   a_q, x_q;
  logic [ID_W-1:0]         id_q;
  logic signed [RESW-1:0]  res_q;
  logic signed [RESW-1:0]  a_ext, x_ext, prod;
  logic [OPW-1:0]          a_arr [NUM_REQ];
  logic [OPW-1:0]          x_arr [NUM_REQ];

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*OPW +: OPW];
    assign x_arr[gi] = req_x[gi*OPW +: OPW];
  end

  rr_arbiter_onehot #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is only offered in IDLE and never while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  // Multiplier core: both operands sign-extended to the full product width,
  // so the 16-bit result is exact (no overflow for 8x8 signed).
  assign a_ext = {{(RESW-OPW){a_q[OPW-1]}}, a_q};
  assign x_ext = {{(RESW-OPW){x_q[OPW-1]}}, x_q};
  assign prod  = a_ext * x_ext;

  assign resp_result = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      a_q        <= '0;
      x_q        <= '0;
      id_q       <= '0;
      res_q      <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            a_q    <= a_arr[gnt_idx];
            x_q    <= x_arr[gnt_idx];
            id_q   <= ID_W'(gnt_idx);
            rr_ptr <= (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
            state  <= MUL;
          end
        end
        MUL: begin
          res_q      <= prod;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SHARE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (resp_valid && resp_ready) perf_ops <= perf_ops + 32'd1;
      if (state != IDLE)            perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_rr.sv
// tb_mult_share_rr: directed, table-driven self-checking bench for
// mult_share_rr (NUM_REQ=4). Inputs change on the falling edge, outputs are
// sampled on the falling edge, the DUT acts on the rising edge.
module tb_mult_share_rr;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*8-1:0]   req_a;
  logic [NUM_REQ*8-1:0]   req_x;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   resp_valid;
  logic [15:0]            resp_result;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_ready;
`ifdef MULT_SHARE_PERF_EN
  logic [31:0]            perf_ops;
  logic [31:0]            perf_busy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_rr #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_x       (req_x),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_id     (resp_id),
    .resp_ready  (resp_ready)
`ifdef MULT_SHARE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_busy   (perf_busy)
`endif
  );

  typedef struct {
    int          req;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] x);
    req_a[8*r +: 8] = a;
    req_x[8*r +: 8] = x;
  endtask

  // One isolated operation from requester r, starting at a falling edge in IDLE.
  task automatic do_op(input int r, input logic [7:0] a, input logic [7:0] x,
                       input logic [15:0] e);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << r;
    @(negedge clk);
    set_ops(r, a, x);
    req_valid = oh;
    #1 chk($sformatf("grant_req%0d", r), 32'(req_ready), 32'(oh));
    @(negedge clk);                       // MUL cycle
    chk("mul_ready_low", 32'(req_ready), 32'd0);
    chk("mul_valid_low", 32'(resp_valid), 32'd0);
    req_valid = '0;
    @(negedge clk);                       // RESP cycle, T+2
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_result", 32'(resp_result), 32'(e));
    chk("resp_id", 32'(resp_id), 32'(r));
    $display("op req%0d a=%h x=%h result=%h id=%0d", r, a, x, resp_result, resp_id);
    @(negedge clk);                       // handshake done, back in IDLE
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]        rr_exp [NUM_REQ];
    logic [NUM_REQ-1:0] oh;
    logic [15:0]        held;

    vecs[0] = '{0, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{2, 8'h80, 8'h7F, 16'hC080};
    vecs[2] = '{1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[3] = '{3, 8'h00, 8'h9C, 16'h0000};
    vecs[4] = '{2, 8'h7F, 8'h7F, 16'h3F01};
    vecs[5] = '{1, 8'h05, 8'hFD, 16'hFFF1};

    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_x      = '0;
    resp_ready = 1'b1;

    // Reset state, with every requester asserting valid.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    rst = 1'b0;

    // Table-driven single operations, including the sign extremes.
    foreach (vecs[i]) do_op(vecs[i].req, vecs[i].a, vecs[i].x, vecs[i].exp);

    // Round-robin with all requesters continuously valid.
    pulse_reset();
    set_ops(0, 8'h03, 8'h04); rr_exp[0] = 16'h000C;
    set_ops(1, 8'hFE, 8'h07); rr_exp[1] = 16'hFFF2;
    set_ops(2, 8'h10, 8'h10); rr_exp[2] = 16'h0100;
    set_ops(3, 8'h81, 8'h02); rr_exp[3] = 16'hFF02;
    @(negedge clk);
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      oh = NUM_REQ'(1) << (n % NUM_REQ);
      #1 chk($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(oh));
      @(negedge clk);
      chk("rr_mul_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rr_resp_id", 32'(resp_id), 32'(n % NUM_REQ));
      chk("rr_resp_result", 32'(resp_result), 32'(rr_exp[n % NUM_REQ]));
      $display("rr grant=%0d result=%h id=%0d", n % NUM_REQ, resp_result, resp_id);
      @(negedge clk);
    end
    req_valid = '0;

    // Backpressure: rr_ptr is 1 here, only req3 valid.
    @(negedge clk);
    resp_ready = 1'b0;
    set_ops(3, 8'h09, 8'h09);
    req_valid = 4'b1000;
    #1 chk("bp_grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    set_ops(2, 8'h02, 8'h03);
    req_valid = 4'b0100;                  // req2 waits during the stall
    @(negedge clk);
    chk("bp_result", 32'(resp_result), 32'h0051);
    held = resp_result;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(resp_valid), 32'd1);
      chk("bp_result_hold", 32'(resp_result), 32'(held));
      chk("bp_id_hold", 32'(resp_id), 32'd3);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
    end
    $display("bp stalled result=%h id=%0d", resp_result, resp_id);
    resp_ready = 1'b1;
    @(negedge clk);                       // handshake taken, IDLE
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_next_grant2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_result", 32'(resp_result), 32'h0006);
    chk("bp_next_id", 32'(resp_id), 32'd2);
    $display("op req2 a=02 x=03 result=%h id=%0d", resp_result, resp_id);
    @(negedge clk);

    // Reset during MUL discards the operation and rewinds rr_ptr.
    set_ops(3, 8'h11, 8'h11);
    req_valid = 4'b1000;
    #1 chk("mid_grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);                       // MUL
    req_valid = '0;
    rst = 1'b1;
    #1 chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    set_ops(1, 8'hF0, 8'hF0);
    set_ops(3, 8'h02, 8'hC0);
    req_valid = 4'b1010;
    #1 chk("post_rst_grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("post_rst_result1", 32'(resp_result), 32'h0100);
    chk("post_rst_id1", 32'(resp_id), 32'd1);
    $display("op req1 a=f0 x=f0 result=%h id=%0d", resp_result, resp_id);
    @(negedge clk);
    #1 chk("post_rst_grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_result3", 32'(resp_result), 32'hFF80);
    chk("post_rst_id3", 32'(resp_id), 32'd3);
    $display("op req3 a=02 x=c0 result=%h id=%0d", resp_result, resp_id);
    @(negedge clk);

`ifdef MULT_SHARE_PERF_EN
    pulse_reset();
    chk("perf_ops_rst", perf_ops, 32'd0);
    chk("perf_busy_rst", perf_busy, 32'd0);
    for (int i = 0; i < 3; i++) do_op(vecs[i].req, vecs[i].a, vecs[i].x, vecs[i].exp);
    chk("perf_ops", perf_ops, 32'd3);
    chk("perf_busy", perf_busy, 32'd6);
    $display("perf ops=%0d busy=%0d", perf_ops, perf_busy);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
